// File: rtl/div_unit.sv
// Sequential signed 32-bit restoring divider for the multicycle datapath.
// Quotient lands in LO, remainder in HI, completion signalled on DivStop.
module div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        DivCtrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        DivStop,
  output logic        DivZero,
  output logic        DivBusy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    ZERO = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        stop_q, stop_d;
  logic        zero_q, zero_d;

  logic [32:0] shl;
  logic [32:0] diff;
  logic        b_zero;

  assign b_zero = (B == 32'd0);

  // Remainder stays below the divisor, so 33 bits always hold the trial sign.
  assign shl  = {rem_q, quo_q[31]};
  assign diff = shl - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      stop_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      stop_q  <= stop_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (DivCtrl) begin
          state_d = b_zero ? ZERO : RUN;
        end
      end
      RUN: begin
        if (cnt_q == 5'd31) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      ZERO:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    stop_d = 1'b0;
    zero_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (DivCtrl && !b_zero) begin
          quo_d = A[31] ? -A : A;
          dvs_d = B[31] ? -B : B;
          sa_d  = A[31];
          sb_d  = B[31];
          rem_d = '0;
          cnt_d = '0;
        end
      end
      RUN: begin
        if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shl[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
      end
      FIN: begin
        lo_d   = (sa_q ^ sb_q) ? -quo_q : quo_q;
        hi_d   = sa_q ? -rem_q : rem_q;
        stop_d = 1'b1;
      end
      ZERO: begin
        stop_d = 1'b1;
        zero_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign HI      = hi_q;
  assign LO      = lo_q;
  assign DivStop = stop_q;
  assign DivZero = zero_q;
  assign DivBusy = (state_q != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver queues expectations,
// monitor checks every DivStop pulse against the queue head.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        DivCtrl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        DivStop;
  logic        DivZero;
  logic        DivBusy;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        z;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic armed = 1'b0;
  logic prev_stop = 1'b0;

  div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .DivCtrl(DivCtrl),
    .A      (A),
    .B      (B),
    .HI     (HI),
    .LO     (LO),
    .DivStop(DivStop),
    .DivZero(DivZero),
    .DivBusy(DivBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      if (DivStop) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_stop: got 1 expected 0");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("HI", HI, e.hi);
          chk("LO", LO, e.lo);
          chk("DivZero", {31'd0, DivZero}, {31'd0, e.z});
          chk("busy_at_stop", {31'd0, DivBusy}, 32'd0);
        end
        if (prev_stop) chk("stop_width", 32'd2, 32'd1);
      end
      if (DivZero && !DivStop) chk("zero_alone", 32'd1, 32'd0);
      prev_stop = DivStop;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input logic ez);
    exp_t e;
    e.hi = ehi;
    e.lo = elo;
    e.z  = ez;
    exp_q.push_back(e);
    @(negedge clk);
    A = a;
    B = b;
    DivCtrl = 1'b1;
    @(posedge clk);
    #1;
    DivCtrl = 1'b0;
    A = $urandom;
    B = $urandom;
    chk("busy_after_start", {31'd0, DivBusy}, 32'd1);
  endtask

  task automatic wait_done(input int lat);
    int n = 0;
    forever begin
      @(posedge clk);
      #1;
      n++;
      if (DivStop) break;
      if (n > 60) break;
    end
    chk("latency", n, lat);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo,
                     input logic ez);
    issue(a, b, ehi, elo, ez);
    wait_done(ez ? 1 : 33);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    DivCtrl = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    chk("rst_stop", {31'd0, DivStop}, 32'd0);
    chk("rst_zero", {31'd0, DivZero}, 32'd0);
    chk("rst_busy", {31'd0, DivBusy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    armed = 1'b1;

    run(32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    run(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run(32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
    run(32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
    repeat (3) @(posedge clk);
    run(32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run(32'd5, 32'd0, 32'd2, 32'd14, 1'b1);
    @(posedge clk);
    #1;
    chk("zero_clear_stop", {31'd0, DivStop}, 32'd0);
    chk("zero_clear_flag", {31'd0, DivZero}, 32'd0);

    // Abort: second start ignored while busy, then reset mid-run.
    issue(32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
    void'(exp_q.pop_back());
    repeat (9) @(posedge clk);
    @(negedge clk);
    DivCtrl = 1'b1;
    A = 32'd9;
    B = 32'd3;
    @(posedge clk);
    #1;
    DivCtrl = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_HI", HI, 32'd0);
    chk("abort_LO", LO, 32'd0);
    chk("abort_stop", {31'd0, DivStop}, 32'd0);
    chk("abort_busy", {31'd0, DivBusy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("idle_after_abort", {31'd0, DivBusy}, 32'd0);

    run(32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0);
    run(32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0);
    run(32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
    run(32'h7FFFFFFF, 32'd1, 32'd0, 32'h7FFFFFFF, 1'b0);
    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Sequential signed 32-bit divider serving the multicycle CPU datapath as the responder to the control unit's divide request. It accepts a one-cycle `DivCtrl` start, runs a restoring shift-subtract loop over the operand magnitudes, and writes the quotient to LO and the remainder to HI. It then returns a one-cycle `DivStop` completion pulse to the control unit. A zero divisor is reported on `DivZero`, so the control unit can branch to its exception path.

## Interface
Parameters:
- none (width fixed at 32)

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-low reset (0 = reset), sampled on rising edge of `clk`
- `DivCtrl`  in  1  start request; sampled only in IDLE
- `A`  in  32  dividend (register A output), two's complement, sampled on accepted start
- `B`  in  32  divisor (register B output), two's complement, sampled on accepted start
- `HI`  out  32  remainder register
- `LO`  out  32  quotient register
- `DivStop`  out  1  registered completion pulse, high exactly one cycle
- `DivZero`  out  1  registered divide-by-zero pulse, high exactly one cycle, coincident with `DivStop`
- `DivBusy`  out  1  high while not in IDLE

## Operation
- States:
  - **IDLE**
    - Stays here while `DivCtrl`=0.
    - If `DivCtrl`=1 and `B`==0: go to ZERO.
    - If `DivCtrl`=1 and `B`!=0: latch `|A|`, `|B|` (unsigned 32-bit), `sA`=`A[31]`, `sB`=`B[31]`; clear the 32-bit partial remainder and the 5-bit counter; go to RUN.
  - **RUN**
    - One restoring step per cycle:
      - Shift {remainder, dividend} left 1.
      - Trial-subtract the divisor magnitude using a 33-bit subtract.
      - If the result is non-negative, keep it and set quotient bit = 1; otherwise restore and set quotient bit = 0.
    - Counter increments each step; after the 32nd step (counter==31) go to FINISH.
  - **FINISH**
    - `LO` <= `sA^sB` ? -Q : Q.
    - `HI` <= `sA` ? -R : R.
    - `DivStop` <= 1; go to IDLE.
  - **ZERO**
    - `DivStop` <= 1 and `DivZero` <= 1; go to IDLE.
    - `HI`/`LO` are not modified.
- Semantics: truncating division toward zero. Remainder takes the dividend's sign, and A == LO*B + HI (mod 2^32).
- Overflow case: 0x80000000 / 0xFFFFFFFF gives `LO`=0x80000000, `HI`=0 (natural 32-bit wrap); no flag.
- `|A|` for A=0x80000000 is 0x80000000 unsigned; magnitude datapath is unsigned 32-bit, no loss.
- `DivCtrl` while `DivBusy`=1: ignored; no queueing, no restart.
- `HI`/`LO` hold their previous values until FINISH; intermediate values are never visible on them.
- `A`/`B` may change after the start cycle without effect.

## Timing
- Reset (`reset`=0 at an edge):
  - state IDLE
  - `HI`=0, `LO`=0
  - `DivStop`=0, `DivZero`=0, `DivBusy`=0
  - counter and work registers cleared
- Reset mid-operation aborts the division; the next cycle is IDLE with the values above.
- Reset dominates `DivCtrl` on the same edge.
- Edge numbering: start accepted at edge 0.
  - Normal path:
    - Edges 1..32 are the RUN steps.
    - Edge 33 (FINISH) writes `HI`, `LO`, and `DivStop`=1.
    - Edge 34 returns `DivStop` to 0.
    - Total latency: 33 cycles from start to results valid.
  - Zero path:
    - Edge 1 sets `DivStop`=1 and `DivZero`=1.
    - Edge 2 clears both.
- `DivBusy` is 1 from edge 0 through the FINISH/ZERO cycle. It is 0 in the cycle `DivStop` is high, because the state is already IDLE.
- A new `DivCtrl` in the same cycle `DivStop` is high is accepted (back-to-back operation).
- `DivStop` and `DivZero` are never high outside these single cycles.

## Test plan
- A=7, B=2, one-cycle `DivCtrl` -> at edge 33: `LO`=3, `HI`=1, `DivStop`=1 for one cycle, `DivZero`=0.
- A=0xFFFFFFF9 (-7), B=2 -> `LO`=0xFFFFFFFD (-3), `HI`=0xFFFFFFFF (-1).
- A=7, B=0xFFFFFFFE (-2) -> `LO`=0xFFFFFFFD, `HI`=1.
- A=0x80000000, B=0xFFFFFFFF -> `LO`=0x80000000, `HI`=0.
- Preload `HI`/`LO` via A=100, B=7 (`LO`=14, `HI`=2), then A=5, B=0 -> edge 1: `DivZero`=`DivStop`=1; `HI`=2, `LO`=14 unchanged; edge 2: both flags 0.
- Start A=100, B=7; pulse `DivCtrl` again at edge 10; drive `reset`=0 at edge 20 -> the second `DivCtrl` has no effect; after the reset edge all outputs are 0 and `DivStop` never pulses; a new start then completes normally in 33 cycles.
